// File: rtl/commit_retire_pkg.sv
// Shared widths, ROB entry layout, exception codes and FSM state type for the
// commit/retire controller and its helpers.
package commit_retire_pkg;

    localparam int COMMIT_WIDTH     = 4;
    localparam int ROB_SIZE         = 16;
    localparam int ROB_ID_WIDTH     = $clog2(ROB_SIZE);
    localparam int PHY_REG_ID_WIDTH = 6;
    localparam int POP_CNT_WIDTH    = $clog2(COMMIT_WIDTH + 1);

    typedef enum logic [3:0] {
        EXC_INST_MISALIGNED  = 4'd0,
        EXC_INST_FAULT       = 4'd1,
        EXC_ILLEGAL_INST     = 4'd2,
        EXC_BREAKPOINT       = 4'd3,
        EXC_LOAD_MISALIGNED  = 4'd4,
        EXC_LOAD_FAULT       = 4'd5,
        EXC_STORE_MISALIGNED = 4'd6,
        EXC_STORE_FAULT      = 4'd7,
        EXC_ECALL_U          = 4'd8,
        EXC_ECALL_S          = 4'd9,
        EXC_ECALL_M          = 4'd11,
        EXC_INST_PAGE_FAULT  = 4'd12,
        EXC_LOAD_PAGE_FAULT  = 4'd13,
        EXC_STORE_PAGE_FAULT = 4'd15
    } riscv_exception_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WALK_START = 2'd1,
        WALK       = 2'd2,
        FLUSH      = 2'd3
    } commit_retire_state_t;

    typedef struct packed {
        logic                        finish;
        logic                        has_exception;
        riscv_exception_t            exception_id;
        logic [31:0]                 exception_value;
        logic                        old_phy_reg_id_valid;
        logic [PHY_REG_ID_WIDTH-1:0] old_phy_reg_id;
        logic [PHY_REG_ID_WIDTH-1:0] new_phy_reg_id;
        logic                        bru_op;
        logic                        predicted_jump;
        logic [31:0]                 predicted_next_pc;
        logic                        bru_jump;
        logic [31:0]                 bru_next_pc;
    } rob_item_t;

    function automatic logic [POP_CNT_WIDTH-1:0] popcount(input logic [COMMIT_WIDTH-1:0] mask);
        logic [POP_CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            cnt = cnt + {{(POP_CNT_WIDTH-1){1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/commit_retire_mispredict_check.sv
// Flags a branch entry whose resolved direction or target differs from the
// prediction made at fetch.
module commit_mispredict_check
    import commit_retire_pkg::*;
(
    input  rob_item_t item,
    output logic      mispredict
);

    logic item_unused_s;

    // Direction or target disagreement on a branch unit op.
    always_comb begin
        mispredict = item.bru_op &&
                     ((item.predicted_jump != item.bru_jump) ||
                      (item.predicted_next_pc != item.bru_next_pc));
    end

    assign item_unused_s = ^{item.finish, item.has_exception, item.exception_id,
                             item.exception_value, item.old_phy_reg_id_valid,
                             item.old_phy_reg_id, item.new_phy_reg_id};

endmodule

// File: rtl/commit_retire.sv
// ROB commit consumer: in-order multi-slot retire, tail-to-head flush walk and
// fetch redirect. Optional retire counter under COMMIT_RETIRE_COUNTER_EN.
module commit_retire
    import commit_retire_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ROB_ID_WIDTH-1:0]     rob_commit_retire_head_id,
    input  logic                        rob_commit_retire_head_id_valid,
    input  rob_item_t                   rob_commit_retire_data [COMMIT_WIDTH],
    input  logic [COMMIT_WIDTH-1:0]     rob_commit_retire_id_valid,
    output logic [ROB_ID_WIDTH-1:0]     commit_rob_retire_id [COMMIT_WIDTH],
    output logic [COMMIT_WIDTH-1:0]     commit_rob_retire_pop,
    input  logic [ROB_ID_WIDTH-1:0]     rob_commit_flush_tail_id,
    input  logic                        rob_commit_flush_tail_id_valid,
    output logic [ROB_ID_WIDTH-1:0]     commit_rob_flush_id,
    input  rob_item_t                   rob_commit_flush_data,
    input  logic [ROB_ID_WIDTH-1:0]     rob_commit_flush_next_id,
    input  logic                        rob_commit_flush_next_id_valid,
    output logic                        commit_rob_flush,
    output logic [PHY_REG_ID_WIDTH-1:0] commit_phyf_free_id [COMMIT_WIDTH],
    output logic [COMMIT_WIDTH-1:0]     commit_phyf_free_valid,
    output logic [PHY_REG_ID_WIDTH-1:0] commit_phyf_flush_free_id,
    output logic                        commit_phyf_flush_free_valid,
    input  logic [31:0]                 mtvec,
    output logic [31:0]                 commit_redirect_pc,
    output logic                        commit_redirect_valid,
    output riscv_exception_t            commit_exception_id,
    output logic [31:0]                 commit_exception_value
`ifdef COMMIT_RETIRE_COUNTER_EN
    ,
    output logic [63:0]                 commit_retire_count
`endif
);

    commit_retire_state_t      state_r, state_nxt_s;
    logic [ROB_ID_WIDTH-1:0]   walk_id_r, walk_id_nxt_s;
    logic [31:0]               redirect_pc_r, redirect_pc_nxt_s;
    riscv_exception_t          exc_id_r, exc_id_nxt_s;
    logic [31:0]               exc_value_r, exc_value_nxt_s;

    logic [COMMIT_WIDTH-1:0]   mispredict_s;
    logic [COMMIT_WIDTH-1:0]   pop_s;
    logic [COMMIT_WIDTH-1:0]   free_valid_s;
    logic                      blocked_s;
    logic                      flush_free_valid_s;
    logic                      flush_s;
    logic                      redirect_valid_s;
    logic                      flush_data_unused_s;

    for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_mispredict
        commit_mispredict_check u_check (
            .item       (rob_commit_retire_data[g]),
            .mispredict (mispredict_s[g])
        );
    end

    // Retire window ids follow the head with natural wraparound.
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commit_rob_retire_id[i] = rob_commit_retire_head_id + ROB_ID_WIDTH'(i);
        end
    end

    // Retire selection, walk sequencing and next-state decode.
    always_comb begin
        state_nxt_s        = state_r;
        walk_id_nxt_s      = walk_id_r;
        redirect_pc_nxt_s  = redirect_pc_r;
        exc_id_nxt_s       = exc_id_r;
        exc_value_nxt_s    = exc_value_r;
        pop_s              = '0;
        free_valid_s       = '0;
        blocked_s          = 1'b0;
        commit_rob_flush_id       = '0;
        commit_phyf_flush_free_id = '0;
        flush_free_valid_s = 1'b0;
        flush_s            = 1'b0;
        redirect_valid_s   = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commit_phyf_free_id[i] = '0;
        end

        case (state_r)
            IDLE: begin
                for (int i = 0; i < COMMIT_WIDTH; i++) begin
                    if (!blocked_s && rob_commit_retire_head_id_valid &&
                        rob_commit_retire_id_valid[i] && rob_commit_retire_data[i].finish) begin
                        if (rob_commit_retire_data[i].has_exception) begin
                            // The faulting entry stays in the ROB; the walk frees it.
                            blocked_s         = 1'b1;
                            redirect_pc_nxt_s = mtvec;
                            exc_id_nxt_s      = rob_commit_retire_data[i].exception_id;
                            exc_value_nxt_s   = rob_commit_retire_data[i].exception_value;
                            state_nxt_s       = WALK_START;
                        end else begin
                            pop_s[i]               = 1'b1;
                            free_valid_s[i]        = rob_commit_retire_data[i].old_phy_reg_id_valid;
                            commit_phyf_free_id[i] = rob_commit_retire_data[i].old_phy_reg_id;
                            blocked_s              = mispredict_s[i];
                            if (mispredict_s[i]) begin
                                redirect_pc_nxt_s = rob_commit_retire_data[i].bru_next_pc;
                                state_nxt_s       = WALK_START;
                            end else begin
                                redirect_pc_nxt_s = redirect_pc_nxt_s;
                            end
                        end
                    end else begin
                        blocked_s = 1'b1;
                    end
                end
            end
            WALK_START: begin
                if (!rob_commit_flush_tail_id_valid) begin
                    state_nxt_s = FLUSH;
                end else begin
                    commit_rob_flush_id       = rob_commit_flush_tail_id;
                    commit_phyf_flush_free_id = rob_commit_flush_data.new_phy_reg_id;
                    flush_free_valid_s        = rob_commit_flush_data.old_phy_reg_id_valid;
                    if (rob_commit_flush_next_id_valid) begin
                        walk_id_nxt_s = rob_commit_flush_next_id;
                        state_nxt_s   = WALK;
                    end else begin
                        state_nxt_s = FLUSH;
                    end
                end
            end
            WALK: begin
                commit_rob_flush_id       = walk_id_r;
                commit_phyf_flush_free_id = rob_commit_flush_data.new_phy_reg_id;
                flush_free_valid_s        = rob_commit_flush_data.old_phy_reg_id_valid;
                if (rob_commit_flush_next_id_valid) begin
                    walk_id_nxt_s = rob_commit_flush_next_id;
                    state_nxt_s   = WALK;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            FLUSH: begin
                flush_s          = 1'b1;
                redirect_valid_s = 1'b1;
                state_nxt_s      = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // While reset is held every strobe is forced low.
    assign commit_rob_retire_pop        = pop_s & {COMMIT_WIDTH{!rst}};
    assign commit_phyf_free_valid       = free_valid_s & {COMMIT_WIDTH{!rst}};
    assign commit_phyf_flush_free_valid = flush_free_valid_s & !rst;
    assign commit_rob_flush             = flush_s & !rst;
    assign commit_redirect_valid        = redirect_valid_s & !rst;
    assign commit_redirect_pc           = redirect_pc_r;
    assign commit_exception_id          = exc_id_r;
    assign commit_exception_value       = exc_value_r;

    assign flush_data_unused_s = ^{rob_commit_flush_data.finish, rob_commit_flush_data.has_exception,
                                   rob_commit_flush_data.exception_id, rob_commit_flush_data.exception_value,
                                   rob_commit_flush_data.old_phy_reg_id, rob_commit_flush_data.bru_op,
                                   rob_commit_flush_data.predicted_jump, rob_commit_flush_data.predicted_next_pc,
                                   rob_commit_flush_data.bru_jump, rob_commit_flush_data.bru_next_pc};

    // FSM state, walk pointer and captured redirect/exception registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            walk_id_r     <= '0;
            redirect_pc_r <= 32'd0;
            exc_id_r      <= EXC_INST_MISALIGNED;
            exc_value_r   <= 32'd0;
        end else begin
            state_r       <= state_nxt_s;
            walk_id_r     <= walk_id_nxt_s;
            redirect_pc_r <= redirect_pc_nxt_s;
            exc_id_r      <= exc_id_nxt_s;
            exc_value_r   <= exc_value_nxt_s;
        end
    end

`ifdef COMMIT_RETIRE_COUNTER_EN
    logic [63:0] retire_count_r;

    // Running total of retired instructions; survives flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count_r <= 64'd0;
        end else begin
            retire_count_r <= retire_count_r + 64'(popcount(commit_rob_retire_pop));
        end
    end

    assign commit_retire_count = retire_count_r;
`else
`endif

endmodule

// File: tb/tb_commit_retire.sv
// Directed bench for commit_retire: a behavioural ROB drives the DUT and a
// scoreboard of expected retire, walk-free and flush events checks its outputs.
module tb_commit_retire;
    import commit_retire_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ROB_ID_WIDTH-1:0]     head_id;
    logic                        head_valid;
    rob_item_t                   retire_data [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]     retire_id_valid;
    logic [ROB_ID_WIDTH-1:0]     retire_id [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]     pop;
    logic [ROB_ID_WIDTH-1:0]     tail_id;
    logic                        tail_valid;
    logic [ROB_ID_WIDTH-1:0]     flush_id;
    rob_item_t                   flush_data;
    logic [ROB_ID_WIDTH-1:0]     next_id;
    logic                        next_valid;
    logic                        rob_flush;
    logic [PHY_REG_ID_WIDTH-1:0] free_id [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]     free_valid;
    logic [PHY_REG_ID_WIDTH-1:0] ffree_id;
    logic                        ffree_valid;
    logic [31:0]                 mtvec;
    logic [31:0]                 redirect_pc;
    logic                        redirect_valid;
    riscv_exception_t            exc_id;
    logic [31:0]                 exc_value;
`ifdef COMMIT_RETIRE_COUNTER_EN
    logic [63:0]                 retire_count;
`endif

    commit_retire dut (
        .clk                             (clk),
        .rst                             (rst),
        .rob_commit_retire_head_id       (head_id),
        .rob_commit_retire_head_id_valid (head_valid),
        .rob_commit_retire_data          (retire_data),
        .rob_commit_retire_id_valid      (retire_id_valid),
        .commit_rob_retire_id            (retire_id),
        .commit_rob_retire_pop           (pop),
        .rob_commit_flush_tail_id        (tail_id),
        .rob_commit_flush_tail_id_valid  (tail_valid),
        .commit_rob_flush_id             (flush_id),
        .rob_commit_flush_data           (flush_data),
        .rob_commit_flush_next_id        (next_id),
        .rob_commit_flush_next_id_valid  (next_valid),
        .commit_rob_flush                (rob_flush),
        .commit_phyf_free_id             (free_id),
        .commit_phyf_free_valid          (free_valid),
        .commit_phyf_flush_free_id       (ffree_id),
        .commit_phyf_flush_free_valid    (ffree_valid),
        .mtvec                           (mtvec),
        .commit_redirect_pc              (redirect_pc),
        .commit_redirect_valid           (redirect_valid),
        .commit_exception_id             (exc_id),
        .commit_exception_value          (exc_value)
`ifdef COMMIT_RETIRE_COUNTER_EN
        ,
        .commit_retire_count             (retire_count)
`endif
    );

    // Behavioural ROB
    rob_item_t               rob_mem [ROB_SIZE];
    logic [ROB_ID_WIDTH-1:0] head_m;
    int                      count_m;

    always_comb begin
        head_id    = head_m;
        head_valid = (count_m > 0);
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            retire_id_valid[i] = (i < count_m);
            retire_data[i]     = rob_mem[retire_id[i]];
        end
        tail_id    = head_m + ROB_ID_WIDTH'(count_m - 1);
        tail_valid = (count_m > 0);
        flush_data = rob_mem[flush_id];
        next_id    = flush_id - ROB_ID_WIDTH'(1);
        next_valid = (count_m > 0) && (flush_id != head_m);
    end

    // Scoreboard
    typedef struct {
        logic [COMMIT_WIDTH-1:0]     pop;
        logic [COMMIT_WIDTH-1:0]     fv;
        logic [PHY_REG_ID_WIDTH-1:0] fid [COMMIT_WIDTH];
    } ret_exp_t;
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } flush_exp_t;

    ret_exp_t                    q_ret[$];
    logic [PHY_REG_ID_WIDTH-1:0] q_walk[$];
    flush_exp_t                  q_flush[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int flush_seen = 0;
    int flush_snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rob_item_t mk(input int id);
        rob_item_t e;
        e = '0;
        e.finish               = 1'b1;
        e.old_phy_reg_id_valid = 1'b1;
        e.old_phy_reg_id       = PHY_REG_ID_WIDTH'(id + 1);
        e.new_phy_reg_id       = PHY_REG_ID_WIDTH'(32 + id);
        return e;
    endfunction

    task automatic load(input int head, input int n);
        for (int k = 0; k < ROB_SIZE; k++) rob_mem[k] = '0;
        for (int k = 0; k < n; k++) rob_mem[(head + k) % ROB_SIZE] = mk((head + k) % ROB_SIZE);
        head_m  = ROB_ID_WIDTH'(head);
        count_m = n;
        cyc     = 0;
    endtask

    task automatic make_branch(input int id, input logic [31:0] target);
        rob_mem[id].bru_op            = 1'b1;
        rob_mem[id].predicted_jump    = 1'b0;
        rob_mem[id].predicted_next_pc = 32'h104;
        rob_mem[id].bru_jump          = 1'b1;
        rob_mem[id].bru_next_pc       = target;
    endtask

    task automatic push_ret(input logic [COMMIT_WIDTH-1:0] p, input int first_id);
        ret_exp_t r;
        r.pop = p;
        r.fv  = p;
        for (int i = 0; i < COMMIT_WIDTH; i++) r.fid[i] = PHY_REG_ID_WIDTH'((first_id + i) % ROB_SIZE + 1);
        q_ret.push_back(r);
    endtask

    task automatic push_flush(input logic [31:0] pc, input int c);
        flush_exp_t f;
        f.pc  = pc;
        f.cyc = c;
        q_flush.push_back(f);
    endtask

    task automatic cycle();
        ret_exp_t   r;
        flush_exp_t f;
        int         npop;
        logic       fl;
        @(negedge clk);
        cyc++;
        npop = 0;
        fl   = rob_flush;
        if (pop != '0) begin
            if (q_ret.size() == 0) begin
                chk("unexpected_pop", 64'(pop), 64'd0);
            end else begin
                r = q_ret.pop_front();
                chk("pop", 64'(pop), 64'(r.pop));
                chk("free_valid", 64'(free_valid), 64'(r.fv));
                for (int i = 0; i < COMMIT_WIDTH; i++)
                    if (r.fv[i]) chk($sformatf("free_id%0d", i), 64'(free_id[i]), 64'(r.fid[i]));
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) npop += int'(pop[i]);
        end
        if (ffree_valid) begin
            if (q_walk.size() == 0) chk("unexpected_walk_free", 64'(ffree_valid), 64'd0);
            else chk("walk_free_id", 64'(ffree_id), 64'(q_walk.pop_front()));
        end
        if (redirect_valid !== rob_flush) chk("redirect_with_flush", 64'(redirect_valid), 64'(rob_flush));
        if (fl) begin
            flush_seen++;
            if (q_flush.size() == 0) begin
                chk("unexpected_flush", 64'(rob_flush), 64'd0);
            end else begin
                f = q_flush.pop_front();
                chk("redirect_pc", 64'(redirect_pc), 64'(f.pc));
                chk("flush_cycle", 64'(cyc), 64'(f.cyc));
            end
        end
        @(posedge clk);
        #1;
        if (fl) begin
            count_m = 0;
        end else begin
            head_m  = head_m + ROB_ID_WIDTH'(npop);
            count_m = count_m - npop;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_ret.size() + q_walk.size() + q_flush.size()) > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_pending", 64'(q_ret.size() + q_walk.size() + q_flush.size()), 64'd0);
        cycle();
        cycle();
    endtask

    initial begin
        rst   = 1'b1;
        mtvec = 32'h8000_0000;
        load(0, 0);
        cycle();
        cycle();
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_flush", 64'(rob_flush), 64'd0);
        chk("rst_ffree_valid", 64'(ffree_valid), 64'd0);
        rst = 1'b0;
        cycle();
        chk("reset_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("reset_free_valid", 64'(free_valid), 64'd0);
        chk("reset_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("reset_exc_value", 64'(exc_value), 64'd0);
`ifdef COMMIT_RETIRE_COUNTER_EN
        chk("reset_count", retire_count, 64'd0);
`endif

        // Full-width retire
        load(0, 4);
        push_ret(4'b1111, 0);
        drain(10);
`ifdef COMMIT_RETIRE_COUNTER_EN
        chk("count_after_4", retire_count, 64'd4);
`endif

        // Unfinished slot 2 stops the prefix, then releases
        load(0, 4);
        rob_mem[2].finish = 1'b0;
        push_ret(4'b0011, 0);
        cycle();
        cycle();
        rob_mem[2].finish = 1'b1;
        push_ret(4'b0011, 2);
        drain(10);

        // Wraparound window 14,15,0,1
        load(14, 4);
        push_ret(4'b1111, 14);
        drain(10);

        // Mispredict in slot 1 over entries 0..6
        load(0, 7);
        make_branch(1, 32'h200);
        push_ret(4'b0011, 0);
        for (int k = 6; k >= 2; k--) q_walk.push_back(PHY_REG_ID_WIDTH'(32 + k));
        push_flush(32'h200, 7);
        drain(20);

        // Exception in slot 0 with three entries
        load(0, 3);
        rob_mem[0].has_exception   = 1'b1;
        rob_mem[0].exception_id    = EXC_ILLEGAL_INST;
        rob_mem[0].exception_value = 32'h55;
        for (int k = 2; k >= 0; k--) q_walk.push_back(PHY_REG_ID_WIDTH'(32 + k));
        push_flush(32'h8000_0000, 5);
        drain(20);
        chk("exc_value", 64'(exc_value), 64'h55);
        chk("exc_id", 64'(exc_id), 64'(EXC_ILLEGAL_INST));

        // Mispredict on the only entry: empty walk
        load(0, 1);
        make_branch(0, 32'h400);
        push_ret(4'b0001, 0);
        push_flush(32'h400, 3);
        drain(20);

        // Mispredict in slot 0 beats an exception in slot 2
        load(0, 4);
        make_branch(0, 32'h300);
        rob_mem[2].has_exception   = 1'b1;
        rob_mem[2].exception_value = 32'hAA;
        push_ret(4'b0001, 0);
        for (int k = 3; k >= 1; k--) q_walk.push_back(PHY_REG_ID_WIDTH'(32 + k));
        push_flush(32'h300, 5);
        drain(20);
        chk("exc_value_kept", 64'(exc_value), 64'h55);

        // Reset in the middle of a walk
        load(0, 7);
        make_branch(1, 32'h200);
        push_ret(4'b0011, 0);
        q_walk.push_back(PHY_REG_ID_WIDTH'(38));
        q_walk.push_back(PHY_REG_ID_WIDTH'(37));
        flush_snap = flush_seen;
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_m = 0;
        chk("rst_walk_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_walk_redirect_pc", 64'(redirect_pc), 64'd0);
        for (int k = 0; k < 6; k++) cycle();
        chk("rst_walk_no_flush", 64'(flush_seen), 64'(flush_snap));
        load(5, 1);
        push_ret(4'b0001, 5);
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
